pulse_gen_multi: RTL
====================

PULSE_GEN_MULTI -- requirements
Module: pulse_gen_multi

Interface
REQ-001 The block SHALL have parameter CHANNELS, default 4, giving the number of independent channels (1..32).
REQ-002 The block SHALL have parameter LEN_W, default 4, giving the width of the pulse-length field (1..8).
REQ-003 The block SHALL have parameter SYNC_STAGES, default 2, giving the input synchroniser depth (0..3; 0 means no synchroniser).
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 level_in  input  CHANNELS  per-channel level inputs, possibly asynchronous.
REQ-007 mode  input  2*CHANNELS  per-channel trigger mode, bits [2i+1:2i]: 00 disabled, 01 rising, 10 falling, 11 both edges.
REQ-008 pulse_len  input  LEN_W  global pulse length in clk cycles; 0 SHALL be treated as 1.
REQ-009 retrigger  input  1  global policy: 1 = an edge during an active pulse restarts it; 0 = the edge is dropped.
REQ-010 clr_missed  input  1  synchronous clear of all missed flags.
REQ-011 pulse_out  output  CHANNELS  registered per-channel output pulses.
REQ-012 missed  output  CHANNELS  registered sticky per-channel dropped-edge flags.

Function
REQ-013 Each channel SHALL pass level_in[i] through SYNC_STAGES flops, giving s[i], then through one history flop, giving h[i].
REQ-014 The rising edge for channel i SHALL be s[i] & !h[i]; the falling edge SHALL be !s[i] & h[i]; the edge is qualified by mode[i] in the same cycle.
REQ-015 Latency: level_in[i] first sampled at its new value at clk edge k SHALL produce pulse_out[i]=1 after edge k+SYNC_STAGES.
REQ-016 Each channel SHALL hold an LEN_W-bit down-counter cnt[i]; L = max(pulse_len,1), sampled in the cycle the qualified edge is detected.
REQ-017 Idle (pulse_out[i]=0) with a qualified edge: pulse_out[i]<=1 and cnt[i]<=L-1.
REQ-018 Active with cnt[i]!=0 and no qualified edge: cnt[i] decrements and pulse_out[i] stays 1.
REQ-019 Active with cnt[i]==0 and no qualified edge: pulse_out[i]<=0; the pulse is exactly L cycles high.
REQ-020 A qualified edge arriving when cnt[i]==0 (last pulse cycle) SHALL be accepted as a new pulse: cnt[i]<=L-1, pulse_out[i] stays 1, missed unaffected, regardless of retrigger.
REQ-021 Active with cnt[i]!=0 and a qualified edge, retrigger=1: cnt[i]<=L-1 (pulse extended); missed unaffected.
REQ-022 Active with cnt[i]!=0 and a qualified edge, retrigger=0: the edge is dropped, counting continues, and missed[i]<=1.
REQ-023 missed[i] SHALL stay set until clr_missed=1; if a set and clr_missed occur in the same cycle, set wins.
REQ-024 A mode or pulse_len change SHALL NOT truncate or lengthen a pulse in progress; it applies only to edges detected afterward; mode=00 suppresses new edges only.
REQ-025 Channels SHALL be fully independent; simultaneous edges on any set of channels are each handled per REQ-017..022.

Reset
REQ-026 While rst=1 at a clk edge, all synchroniser flops, h, cnt, pulse_out and missed SHALL load 0.
REQ-027 After reset, an input already high SHALL be seen as a rising edge (history is 0), giving a pulse if mode enables rising.
REQ-028 Reset asserted mid-pulse SHALL force pulse_out to 0 after the next clk edge with no residual pulse afterward.

Verification
REQ-029 SYNC_STAGES=2, mode[0]=01, pulse_len=3, level_in[0] rises before edge k -> pulse_out[0] is high after edges k+2..k+4, low after k+5.
REQ-030 mode=11, pulse_len=0, level_in[1] toggles every 4 cycles -> pulse_out[1] gives one 1-cycle pulse per toggle, missed[1]=0.
REQ-031 pulse_len=5, retrigger=0, a second edge 2 cycles into the pulse -> pulse stays 5 cycles and missed=1; clr_missed -> missed=0 on the next cycle.
REQ-032 pulse_len=5, retrigger=1, same stimulus as REQ-031 -> pulse is 7 cycles high and missed=0; an edge on the last pulse cycle gives continuous high with no gap.
REQ-033 Input high through reset release, mode=01 -> exactly one pulse after SYNC_STAGES edges; rst=1 mid-pulse -> pulse_out=0 and missed=0 after the next edge.
REQ-034 Four channels with different modes driven by simultaneous edges -> each pulse_out matches its mode with no crosstalk; same-cycle set of missed and clr_missed=1 -> missed stays 1.

Source files
------------

// File: rtl/pulse_gen_multi.sv
// rtl/pulse_gen_multi.sv - multi-channel edge-triggered pulse generator
module pulse_gen_multi #(
    parameter int CHANNELS    = 4,
    parameter int LEN_W       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [CHANNELS-1:0]     level_in,
    input  logic [2*CHANNELS-1:0]   mode,
    input  logic [LEN_W-1:0]        pulse_len,
    input  logic                    retrigger,
    input  logic                    clr_missed,
    output logic [CHANNELS-1:0]     pulse_out,
    output logic [CHANNELS-1:0]     missed
);

    logic [CHANNELS-1:0] s;
    logic [CHANNELS-1:0] h;
    logic [CHANNELS-1:0] qual;
    logic [CHANNELS-1:0] drop;
    logic [LEN_W-1:0]    len_eff;
    logic [LEN_W-1:0]    len_m1;
    logic [LEN_W-1:0]    cnt [CHANNELS];

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign s = level_in;
        end else begin : g_sync
            logic [CHANNELS-1:0] sync_q [SYNC_STAGES];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int j = 0; j < SYNC_STAGES; j++) begin
                        sync_q[j] <= '0;
                    end
                end else begin
                    sync_q[0] <= level_in;
                    for (int j = 1; j < SYNC_STAGES; j++) begin
                        sync_q[j] <= sync_q[j-1];
                    end
                end
            end

            assign s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    // A zero length still yields a one-cycle pulse.
    assign len_eff = (pulse_len == '0) ? LEN_W'(1) : pulse_len;
    assign len_m1  = len_eff - LEN_W'(1);

    always_comb begin
        qual = '0;
        drop = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            qual[i] = (mode[2*i]   &  s[i] & ~h[i]) |
                      (mode[2*i+1] & ~s[i] &  h[i]);
            // Only an edge landing mid-pulse (not on the last cycle) can be lost.
            drop[i] = pulse_out[i] & qual[i] & (cnt[i] != '0) & ~retrigger;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h         <= '0;
            pulse_out <= '0;
            missed    <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            h      <= s;
            missed <= (missed & ~{CHANNELS{clr_missed}}) | drop;
            for (int i = 0; i < CHANNELS; i++) begin
                if (!pulse_out[i]) begin
                    if (qual[i]) begin
                        pulse_out[i] <= 1'b1;
                        cnt[i]       <= len_m1;
                    end
                end else if (qual[i] && (cnt[i] == '0 || retrigger)) begin
                    cnt[i] <= len_m1;
                end else if (cnt[i] == '0) begin
                    pulse_out[i] <= 1'b0;
                end else begin
                    cnt[i] <= cnt[i] - LEN_W'(1);
                end
            end
        end
    end

endmodule
